// File: rtl/rggen_apb_adapter_pkg.sv
// Shared types and helpers for the APB register-block front end.
// Holds the FSM state encoding and the address-window decode.
package rggen_apb_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    function automatic int strobe_width(
        input int data_width
    );
        return data_width / 8;
    endfunction

    // Upper address bits must equal the base's upper bits.
    function automatic logic window_match(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          local_width
    );
        return (addr >> local_width) == (base >> local_width);
    endfunction

endpackage

// File: rtl/rggen_watchdog_counter.sv
// Saturating cycle counter that flags the last allowed cycle.
// A LIMIT of zero removes the counter and never expires.
module rggen_watchdog_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (LIMIT == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, clear, enable};
        assign expired = 1'b0;
    end else begin : g_on
        localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

        logic [WIDTH-1:0] count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable && (count != LAST)) begin
                count <= count + 1'b1;
            end
        end

        assign expired = enable && (count == LAST);
    end

endmodule

// File: rtl/rggen_apb_adapter.sv
// APB4 slave front end driving a single-outstanding register bus.
// Registered pready/prdata/pslverr; window decode and watchdog.
module rggen_apb_adapter
    import rggen_apb_adapter_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH       = 16,
    parameter int                     DATA_WIDTH          = 32,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
    parameter int                     TIMEOUT_CYCLES      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [ADDRESS_WIDTH-1:0]       paddr,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic                           register_valid,
    output logic                           register_write,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] register_address,
    output logic [DATA_WIDTH-1:0]          register_write_data,
    output logic [DATA_WIDTH/8-1:0]        register_strobe,
    input  logic                           register_ready,
    input  logic                           register_error,
    input  logic [DATA_WIDTH-1:0]          register_read_data
);

    localparam int STROBE_WIDTH = strobe_width(DATA_WIDTH);
    localparam int WD_WIDTH =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_dw
        $error("DATA_WIDTH must be 32 or 64");
    end
    if (LOCAL_ADDRESS_WIDTH > ADDRESS_WIDTH) begin : g_bad_law
        $error("LOCAL_ADDRESS_WIDTH exceeds ADDRESS_WIDTH");
    end
    if (ADDRESS_WIDTH > 64) begin : g_bad_aw
        $error("ADDRESS_WIDTH must be at most 64");
    end
    if (BASE_ADDRESS[LOCAL_ADDRESS_WIDTH-1:0] != '0) begin : g_bad_base
        $error("BASE_ADDRESS not aligned to window");
    end

    state_t state;
    logic   abort;
    logic   hit;
    logic   expired;
    logic   setup;
    logic   done;

    assign setup = psel && !penable;
    assign done  = register_ready || expired;
    assign hit   = window_match(64'(paddr), 64'(BASE_ADDRESS),
                                LOCAL_ADDRESS_WIDTH);

    rggen_watchdog_counter #(
        .WIDTH (WD_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ACCESS),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            abort               <= 1'b0;
            pready              <= 1'b0;
            pslverr             <= 1'b0;
            prdata              <= '0;
            register_valid      <= 1'b0;
            register_write      <= 1'b0;
            register_address    <= '0;
            register_write_data <= '0;
            register_strobe     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    pready <= 1'b0;
                    if (setup && hit) begin
                        state            <= ACCESS;
                        abort            <= 1'b0;
                        register_valid   <= 1'b1;
                        register_write   <= pwrite;
                        register_address <=
                            paddr[LOCAL_ADDRESS_WIDTH-1:0];
                        register_write_data <=
                            pwrite ? pwdata : '0;
                        register_strobe  <=
                            pwrite ? pstrb : {STROBE_WIDTH{1'b1}};
                    end else if (setup) begin
                        state   <= RESPOND;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= '0;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        abort <= 1'b1;
                    end
                    // An abandoned transfer completes silently.
                    if (done && (abort || !psel)) begin
                        state          <= IDLE;
                        register_valid <= 1'b0;
                    end else if (done) begin
                        state          <= RESPOND;
                        register_valid <= 1'b0;
                        pready         <= 1'b1;
                        pslverr <= register_ready ?
                                   register_error : 1'b1;
                        prdata  <=
                            (register_ready && !register_write) ?
                            register_read_data : '0;
                    end
                end
                RESPOND: begin
                    pready <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rggen_apb_adapter.md
Name: rggen_apb_adapter

Overview:
- Parametrised APB4 slave front end for a generated register block.
- Accepts APB transfers, decodes a base-address window and drives a single-outstanding internal register-access bus.
- Returns read data and status to APB with registered pready.
- Adds behaviour a plain APB bundle lacks: wait-state sequencing, out-of-window error, optional watchdog timeout, read/write strobe normalisation.

Parameters:
ADDRESS_WIDTH, 16, APB paddr width
DATA_WIDTH, 32, data width; 32 or 64 only (elaboration error otherwise)
LOCAL_ADDRESS_WIDTH, 8, width of decoded window; must be <= ADDRESS_WIDTH
BASE_ADDRESS, 0, window base; low LOCAL_ADDRESS_WIDTH bits must be zero
TIMEOUT_CYCLES, 16, internal-bus watchdog limit; 0 disables timeout

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable
paddr  input  ADDRESS_WIDTH  APB address
pwrite  input  1  APB direction
pwdata  input  DATA_WIDTH  APB write data
pstrb  input  DATA_WIDTH/8  APB write strobe
pready  output  1  APB ready (registered)
prdata  output  DATA_WIDTH  APB read data (registered)
pslverr  output  1  APB error (registered)
register_valid  output  1  internal access request
register_write  output  1  1=write, 0=read
register_address  output  LOCAL_ADDRESS_WIDTH  byte address within window
register_write_data  output  DATA_WIDTH  write data
register_strobe  output  DATA_WIDTH/8  byte enables
register_ready  input  1  internal access complete
register_error  input  1  internal error, valid with register_ready
register_read_data  input  DATA_WIDTH  read data, valid with register_ready

Behaviour:
- Reset: state IDLE; pready=0, pslverr=0, prdata=0, register_valid=0, register_write=0, register_address=0, register_write_data=0, register_strobe=0, watchdog=0.
- FSM states:
  - IDLE. Setup phase (psel=1, penable=0):
    - Address in window [BASE, BASE+2^LOCAL_ADDRESS_WIDTH): capture direction/address/data/strobe, go ACCESS.
    - Out of window: go RESPOND with pslverr=1, prdata=0; no internal access.
  - ACCESS: register_valid=1; request fields held stable. Watchdog increments each cycle.
    - register_ready=1: capture register_read_data (reads; 0 on writes) and register_error into prdata/pslverr, go RESPOND.
    - Else if TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1: drop request, pslverr=1, prdata=0, go RESPOND.
  - RESPOND: pready=1 for exactly one cycle, then IDLE. prdata/pslverr hold until the next response.
- Latency:
  - In-window access with register_ready in the first ACCESS cycle: setup at T, register_valid at T+1, pready at T+2 (one APB wait state).
  - Out-of-window: pready at T+1.
- register_ready and timeout in the same cycle: ready wins, no error.
- Strobe: writes pass pstrb; reads drive all-ones. A write with pstrb=0 is still issued.
- Address: register_address = paddr[LOCAL_ADDRESS_WIDTH-1:0]; the unaligned low bits are passed unchanged.
- psel deasserted while in ACCESS (protocol violation): request held until ready/timeout, response discarded, return to IDLE with pready=0.
- New setup phase seen outside IDLE: ignored.
- rst_n assertion mid-access: immediate return to reset values; no response generated.
- Watchdog saturates and clears on entry to ACCESS.

Decomposition:
- Package rggen_apb_adapter_pkg:
  - state enum {IDLE, ACCESS, RESPOND}
  - localparam STROBE_WIDTH = DATA_WIDTH/8 as a function helper
  - window-match function
- Sub-module rggen_watchdog_counter:
  - parameters WIDTH, LIMIT
  - inputs clear, enable
  - output expired
  - tied off when LIMIT=0

Test Plan:
- Write 0xDEADBEEF to paddr=0x0004, pstrb=0xF, register_ready on first ACCESS cycle -> register_valid at T+1 with address 0x04, write_data 0xDEADBEEF, strobe 0xF; pready=1, pslverr=0 at T+2.
- Read from 0x0010, register_read_data=0x12345678 after 3 wait cycles -> prdata=0x12345678, pslverr=0, pready exactly one cycle; register_strobe=0xF throughout.
- BASE_ADDRESS=0x1000, read paddr=0x0200 -> no register_valid; pready=1, pslverr=1, prdata=0 at T+1.
- TIMEOUT_CYCLES=4, register_ready held 0 -> register_valid high 4 cycles then low; pready=1 with pslverr=1 next cycle. Repeat with ready asserted on the 4th cycle -> pslverr=0.
- register_error=1 with ready on a write -> pslverr=1. Back-to-back second transfer completes with pslverr=0.
- Drop rst_n during ACCESS -> all outputs 0 asynchronously; after release, a fresh read to 0x0000 completes normally.
